// File: rtl/fifo_wr_framer.sv
// Write-side framer: buffers one producer frame, then pushes a length header and the payload into the FIFO.
// Optional checksum trailer (XOR of the payload words) is enabled by defining FRAMER_CHECKSUM_EN.
module fifo_wr_framer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] fifo_data,
  output logic             fifo_wr,
  input  logic             fifo_full,
  output logic             frame_drop,
  output logic             busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {COLLECT, DROP, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [1:0] {COLLECT, DROP, HEADER, PAYLOAD} state_t;
`endif

  state_t           state, state_nxt;
  logic [LEN_W-1:0] wr_idx, wr_idx_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
  logic             drop_nxt;
  logic             mem_we;
  logic             beat;
  logic             push;
  logic             last_rd;
  logic [WIDTH-1:0] frame_mem [MAX_LEN];
`ifdef FRAMER_CHECKSUM_EN
  logic [WIDTH-1:0] csum, csum_nxt;
`endif

  // Output decode from registered state only, followed by next-state logic.
  always_comb begin
    s_ready    = 1'b0;
    fifo_wr    = 1'b0;
    busy       = 1'b0;
    fifo_data  = '0;
    state_nxt  = state;
    wr_idx_nxt = wr_idx;
    rd_idx_nxt = rd_idx;
    len_nxt    = len;
    drop_nxt   = 1'b0;
    mem_we     = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
    csum_nxt   = csum;
`endif

    unique case (state)
      COLLECT, DROP: s_ready = ~rst_wr;
      HEADER: begin
        fifo_wr   = 1'b1;
        busy      = 1'b1;
        fifo_data = WIDTH'(len);
      end
      PAYLOAD: begin
        fifo_wr   = 1'b1;
        busy      = 1'b1;
        fifo_data = frame_mem[rd_idx];
      end
`ifdef FRAMER_CHECKSUM_EN
      TRAILER: begin
        fifo_wr   = 1'b1;
        busy      = 1'b1;
        fifo_data = csum;
      end
`endif
      default: ;
    endcase

    beat    = s_valid & s_ready;
    push    = fifo_wr & ~fifo_full;
    last_rd = (LEN_W'(rd_idx) == (len - LEN_W'(1)));

    unique case (state)
      COLLECT: begin
        if (beat) begin
          if (wr_idx < LEN_W'(MAX_LEN)) begin
            mem_we = 1'b1;
`ifdef FRAMER_CHECKSUM_EN
            csum_nxt = (wr_idx == '0) ? s_data : (csum ^ s_data);
`endif
            if (s_last) begin
              len_nxt    = wr_idx + LEN_W'(1);
              wr_idx_nxt = '0;
              state_nxt  = HEADER;
            end else begin
              wr_idx_nxt = wr_idx + LEN_W'(1);
            end
          end else if (s_last) begin
            // Buffer already full: this word makes the frame oversized.
            drop_nxt   = 1'b1;
            wr_idx_nxt = '0;
`ifdef FRAMER_CHECKSUM_EN
            csum_nxt   = '0;
`endif
          end else begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (beat && s_last) begin
          drop_nxt   = 1'b1;
          wr_idx_nxt = '0;
          state_nxt  = COLLECT;
`ifdef FRAMER_CHECKSUM_EN
          csum_nxt   = '0;
`endif
        end
      end
      HEADER: begin
        if (push) begin
          rd_idx_nxt = '0;
          state_nxt  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (push) begin
          if (last_rd) begin
`ifdef FRAMER_CHECKSUM_EN
            state_nxt = TRAILER;
`else
            state_nxt = COLLECT;
`endif
          end else begin
            rd_idx_nxt = rd_idx + IDX_W'(1);
          end
        end
      end
`ifdef FRAMER_CHECKSUM_EN
      TRAILER: begin
        if (push) state_nxt = COLLECT;
      end
`endif
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Indices, length and drop pulse; reset discards any partial frame.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      len        <= '0;
      frame_drop <= 1'b0;
    end else begin
      wr_idx     <= wr_idx_nxt;
      rd_idx     <= rd_idx_nxt;
      len        <= len_nxt;
      frame_drop <= drop_nxt;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) csum <= '0;
    else        csum <= csum_nxt;
  end
`endif

  // Frame buffer needs no reset: len gates which entries are ever read.
  always_ff @(posedge clk_wr) begin
    if (mem_we) frame_mem[IDX_W'(wr_idx)] <= s_data;
  end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Scoreboard bench for fifo_wr_framer: a frame-level model queues expected FIFO words, a monitor pops and compares.
module tb_fifo_wr_framer;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 16;
`ifdef FRAMER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic             clk_wr = 1'b0;
  logic             rst_wr = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_wr;
  logic             fifo_full;
  logic             frame_drop;
  logic             busy;

  bit   full_mode  = 1'b0;
  logic full_force = 1'b0;
  logic full_rnd   = 1'b0;
  assign fifo_full = full_mode ? full_rnd : full_force;

  fifo_wr_framer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .fifo_full(fifo_full), .frame_drop(frame_drop), .busy(busy)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct packed {
    logic             eof;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] cur_q[$];
  logic [WIDTH-1:0] frame_words[$];
  logic [WIDTH-1:0] wlog[$];
  logic [WIDTH-1:0] want_log[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int hdr_due = -1, hdr_len = 0, drop_due = -1, ready_due = -1, last_push = -1;
  int drops_exp = 0, drops_seen = 0;

  always @(posedge clk_wr) begin
    cyc      <= cyc + 1;
    full_rnd <= ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a completed frame of n<=MAX_LEN words yields header n, the words, optional XOR trailer.
  task automatic model_beat(input logic [WIDTH-1:0] d, input bit last);
    exp_t e;
    logic [WIDTH-1:0] x;
    cur_q.push_back(d);
    if (last) begin
      if (cur_q.size() <= MAX_LEN) begin
        x = '0;
        e.eof = 1'b0; e.data = WIDTH'(cur_q.size());
        exp_q.push_back(e);
        foreach (cur_q[i]) begin
          x ^= cur_q[i];
          e.eof = (i == cur_q.size() - 1) && !CSUM;
          e.data = cur_q[i];
          exp_q.push_back(e);
        end
        if (CSUM) begin
          e.eof = 1'b1; e.data = x;
          exp_q.push_back(e);
        end
        hdr_due   = cyc + 1;
        hdr_len   = cur_q.size();
        last_push = cyc;
      end else begin
        drop_due = cyc + 1;
        drops_exp++;
      end
      cur_q.delete();
    end
  endtask

  // Monitor: samples mid-cycle, the values the DUT acts on at the next rising edge.
  always @(negedge clk_wr) begin
    exp_t e;
    if (!rst_wr) begin
      chk("busy_eq_wr", 32'(busy), 32'(fifo_wr));
      if (fifo_wr) chk("ready_low_in_drain", 32'(s_ready), 32'd0);
      chk("frame_drop", 32'(frame_drop), 32'(cyc == drop_due));
      if (frame_drop) drops_seen++;
      if (cyc == hdr_due) begin
        chk("hdr_wr", 32'(fifo_wr), 32'd1);
        chk("hdr_len", 32'(fifo_data), 32'(hdr_len));
      end
      if (cyc == ready_due) chk("ready_after_drain", 32'(s_ready), 32'd1);
      if (exp_q.size() > 0 && cyc > last_push) chk("drain_wr", 32'(fifo_wr), 32'd1);
      if (fifo_wr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got data 0x%0h, expected no write (cycle %0d)", fifo_data, cyc);
        end else if (fifo_full) begin
          chk("stall_data", 32'(fifo_data), 32'(exp_q[0].data));
        end else begin
          e = exp_q.pop_front();
          chk("fifo_data", 32'(fifo_data), 32'(e.data));
          wlog.push_back(fifo_data);
          if (e.eof) ready_due = cyc + 1;
        end
      end
    end
  end

  // Drive frame_words as one frame, holding each word until accepted; gap is % chance of an idle cycle.
  task automatic send_frame(input int gap);
    int i, waits;
    i = 0; waits = 0;
    while (i < frame_words.size()) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        s_valid = 1'b0; s_data = WIDTH'($urandom); s_last = 1'($urandom);
      end else begin
        s_valid = 1'b1; s_data = frame_words[i]; s_last = (i == frame_words.size() - 1);
      end
      @(negedge clk_wr);
      if (s_valid && s_ready) begin
        model_beat(s_data, s_last);
        i++; waits = 0;
      end else begin
        waits++;
        if (waits > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: got no s_ready for 200 cycles, expected acceptance");
          break;
        end
      end
      @(posedge clk_wr); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 500) begin
      @(negedge clk_wr);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
    @(posedge clk_wr); #1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(wlog.size()), 32'(want_log.size()));
    foreach (want_log[i]) if (i < wlog.size()) chk(name, 32'(wlog[i]), 32'(want_log[i]));
    wlog.delete();
  endtask

  task automatic rand_frame(input int lo, input int hi);
    int n;
    n = $urandom_range(hi, lo);
    frame_words.delete();
    for (int k = 0; k < n; k++) frame_words.push_back(WIDTH'($urandom));
  endtask

  initial begin
    #1 rst_wr = 1'b1;
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_wr", 32'(fifo_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_drop", 32'(frame_drop), 32'd0);
    repeat (3) @(posedge clk_wr);
    #1 rst_wr = 1'b0;
    @(negedge clk_wr);
    chk("ready_after_reset", 32'(s_ready), 32'd1);
    @(posedge clk_wr); #1;

    // Three-word frame.
    frame_words = {8'h11, 8'h22, 8'h33};
    send_frame(0); wait_idle();
    want_log = {8'h03, 8'h11, 8'h22, 8'h33};
    if (CSUM) want_log.push_back(8'h00);
    check_log("frame3");

    // Single-word frame.
    frame_words = {8'hA5};
    send_frame(0); wait_idle();
    want_log = {8'h01, 8'hA5};
    if (CSUM) want_log.push_back(8'hA5);
    check_log("frame1");

    // Maximum-length frame 0..15.
    frame_words.delete();
    for (int k = 0; k < MAX_LEN; k++) frame_words.push_back(WIDTH'(k));
    send_frame(0); wait_idle();
    want_log = {8'h10};
    for (int k = 0; k < MAX_LEN; k++) want_log.push_back(WIDTH'(k));
    if (CSUM) want_log.push_back(8'h00);
    check_log("frame_max");

    // Oversized frame, then a 2-word frame.
    rand_frame(MAX_LEN + 1, MAX_LEN + 1);
    send_frame(0);
    repeat (4) @(posedge clk_wr); #1;
    chk("drop_no_writes", 32'(wlog.size()), 32'd0);
    chk("drop_pulses", 32'(drops_seen), 32'(drops_exp));
    rand_frame(2, 2);
    send_frame(0); wait_idle();
    wlog.delete();

    // FIFO full stall right after the header push.
    frame_words = {8'h01, 8'h02};
    send_frame(0);
    @(posedge clk_wr); #1;
    full_force = 1'b1;
    repeat (5) @(posedge clk_wr);
    #1 full_force = 1'b0;
    wait_idle();
    want_log = {8'h02, 8'h01, 8'h02};
    if (CSUM) want_log.push_back(8'h03);
    check_log("stall");

    // Asynchronous reset in the middle of the payload.
    rand_frame(8, 8);
    send_frame(0);
    repeat (2) @(posedge clk_wr);
    #3 rst_wr = 1'b1;
    exp_q.delete(); cur_q.delete();
    #1;
    chk("midrst_wr", 32'(fifo_wr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(s_ready), 32'd0);
    repeat (2) @(posedge clk_wr);
    #1 rst_wr = 1'b0;
    wlog.delete();
    @(posedge clk_wr); #1;
    frame_words = {8'h7E};
    send_frame(0); wait_idle();
    want_log = {8'h01, 8'h7E};
    if (CSUM) want_log.push_back(8'h7E);
    check_log("after_rst");

    // Back-to-back frames with s_valid held high.
    for (int f = 0; f < 5; f++) begin
      rand_frame(1, MAX_LEN);
      send_frame(0);
    end
    wait_idle();

    // Random lengths (including oversized), idle gaps and random FIFO backpressure.
    full_mode = 1'b1;
    for (int f = 0; f < 25; f++) begin
      rand_frame(1, MAX_LEN + 3);
      send_frame(25);
    end
    full_mode = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk_wr); #1;
    chk("drop_total", 32'(drops_seen), 32'(drops_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_framer.md
Name: fifo_wr_framer

Overview:
- Write-side framing stage that sits directly upstream of the dual-clock FIFO, entirely in the write clock domain.
- Collects a variable-length payload from a producer valid/ready stream into a local frame buffer.
- Once the frame is complete, pushes a length header word followed by the payload words into the FIFO write port, honouring the FIFO full flag.
- Oversized frames are discarded whole, so the read side only ever sees complete, well-formed frames.

Parameters:
- WIDTH, 8: data word width; must equal the downstream FIFO width.
- MAX_LEN, 16: maximum payload words per frame. Constraint: $clog2(MAX_LEN+1) <= WIDTH.

Ports:
- clk_wr  in  1  write-domain clock.
- rst_wr  in  1  reset, asynchronous, active-high.
- s_data  in  WIDTH  producer payload word.
- s_valid  in  1  producer word valid.
- s_last  in  1  marks the final word of a frame; qualified by s_valid.
- s_ready  out  1  framer can take a word.
- fifo_data  out  WIDTH  word presented to the FIFO data_in.
- fifo_wr  out  1  write request to the FIFO wr input.
- fifo_full  in  1  FIFO full flag (combinational, write domain).
- frame_drop  out  1  one-cycle pulse when an oversized frame has been discarded.
- busy  out  1  high in HEADER/PAYLOAD (and TRAILER when enabled).

Behaviour:
- Handshake definitions:
  - Input beat = s_valid & s_ready, sampled on posedge clk_wr.
  - FIFO push = fifo_wr & ~fifo_full.
  - fifo_wr may stay high while fifo_full=1; a word is consumed only on a push cycle.
- Reset (rst_wr=1, asynchronous): state=COLLECT, wr_idx=0, rd_idx=0, len=0.
  - frame_drop=0, fifo_wr=0, busy=0, fifo_data=0.
  - s_ready is forced to 0 while rst_wr is high.
- Reset mid-frame discards the partial frame and its buffer contents; no partial frame reaches the FIFO.
- s_ready=1 only in COLLECT and DROP.
- fifo_wr=1 only in HEADER and PAYLOAD (and TRAILER when enabled).
- fifo_wr, fifo_data and busy are decoded from registered state, index and buffer contents only. They must not depend combinationally on fifo_full or s_valid.
- COLLECT:
  - On a beat with wr_idx<MAX_LEN: buf[wr_idx]<=s_data; wr_idx<=wr_idx+1.
  - If that beat has s_last: len<=wr_idx+1, wr_idx<=0, next=HEADER.
  - On a beat with wr_idx==MAX_LEN: the word is discarded.
    - With s_last: pulse frame_drop next cycle, wr_idx<=0, stay in COLLECT.
    - Without s_last: next=DROP.
- DROP:
  - Accept and discard every word.
  - On the s_last beat: frame_drop pulses for one cycle, wr_idx<=0, next=COLLECT.
- HEADER:
  - fifo_data = len, zero-extended to WIDTH.
  - On push: rd_idx<=0, next=PAYLOAD.
- PAYLOAD:
  - fifo_data = buf[rd_idx].
  - On push: if rd_idx==len-1, next=COLLECT (TRAILER when enabled); otherwise rd_idx<=rd_idx+1.
- Latency:
  - Header is presented the cycle after the s_last beat.
  - With the FIFO never full, the frame drains in exactly len+1 consecutive cycles.
  - The next frame may start being accepted the cycle after the last payload push.
- Boundaries:
  - len=1 gives header plus one payload word.
  - len=MAX_LEN is legal and is not dropped.
  - fifo_full going high mid-frame stalls with fifo_data held stable; the drain resumes with no word lost or duplicated.
  - fifo_full is ignored in COLLECT and DROP.
  - s_valid, s_last and s_data are don't-care when s_ready=0.
- Widths:
  - wr_idx and len are $clog2(MAX_LEN+1) bits.
  - rd_idx is $clog2(MAX_LEN) bits (minimum 1).
  - There is no wrap: the indices never exceed MAX_LEN.

Optional Feature:
- Macro FRAMER_CHECKSUM_EN.
- When defined:
  - Adds a TRAILER state after PAYLOAD.
  - fifo_data = XOR of all payload words of the frame, accumulated during COLLECT.
  - The accumulator is cleared on the first beat of each frame, on drop, and on reset.
  - On push, next=COLLECT.
  - The header value remains the payload count (the trailer is not counted).
  - The drain takes len+2 cycles.
- When not defined: no TRAILER state, no accumulator logic, and PAYLOAD returns directly to COLLECT.

Test Plan:
- Reset held, then released with FIFO not full, frame 0x11,0x22,0x33 (last on 0x33): FIFO receives 0x03,0x11,0x22,0x33 on consecutive cycles. s_ready=0 during the drain, back to 1 the cycle after the last push. With checksum: trailer 0x00.
- Single-word frame 0xA5 with last: FIFO receives 0x01,0xA5. With checksum: trailer 0xA5.
- MAX_LEN=16 frame of words 0..15: header 0x10, then 16 payload words, no frame_drop. A 17-word frame: frame_drop pulses exactly once after its last beat, no FIFO writes, and the next 2-word frame passes intact.
- fifo_full raised for 5 cycles after the header push of frame 0x01,0x02: fifo_wr stays 1, fifo_data holds 0x01 throughout the stall. Afterwards 0x01,0x02 are written exactly once each.
- rst_wr asserted asynchronously mid-PAYLOAD: fifo_wr=0 and busy=0 immediately. After release, a new frame 0x7E produces only 0x01,0x7E.
- Back-to-back frames, s_valid always high: words offered while s_ready=0 are not consumed. FIFO content equals the exact concatenation of header+payload per frame.
